cache_rd_arbiter: RTL

// - Shares one CacheBus read port (AR/R channels) among N cache-side requesters (icache, dcache, prefetcher).
// - Arbitrates AR requests, holds the winner in a one-entry output register, and prepends the requester index to ar_id.
// - Routes R beats back by that index and bounds in-flight bursts with a counter.
// - Sits between the L1 miss units and the L2/bus CacheBus slaver port.

---
 rtl/cache_rd_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_rd_arbiter.sv
// Read-port arbiter: N requesters share one downstream AR/R port; AR is registered, R routed by id prefix.
// Optional macro CACHE_RD_ARB_PRIO_EN gives requester 0 strict priority over a round-robin of the rest.
module cache_rd_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 2,
  parameter int USER_WIDTH = 1,
  parameter int MAX_OUTST  = 8,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  // Handshake: a transfer happens on a cycle where valid and ready are both high at the rising edge;
  // ready never depends on a transfer elsewhere in the same cycle except m_ar_ready draining the AR slot.
  input  logic [N_REQ-1:0]                 s_ar_valid,
  output logic [N_REQ-1:0]                 s_ar_ready,
  input  logic [N_REQ*ID_WIDTH-1:0]        s_ar_id,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      s_ar_addr,
  input  logic [N_REQ*8-1:0]               s_ar_len,
  input  logic [N_REQ*3-1:0]               s_ar_size,
  input  logic [N_REQ*2-1:0]               s_ar_burst,
  input  logic [N_REQ*4-1:0]               s_ar_snoop,
  input  logic [N_REQ*USER_WIDTH-1:0]      s_ar_user,
  output logic [N_REQ-1:0]                 s_r_valid,
  input  logic [N_REQ-1:0]                 s_r_ready,
  output logic [ID_WIDTH-1:0]              s_r_id,
  output logic [DATA_WIDTH-1:0]            s_r_data,
  output logic [4:0]                       s_r_resp,
  output logic                             s_r_last,
  output logic [USER_WIDTH-1:0]            s_r_user,
  output logic                             m_ar_valid,
  input  logic                             m_ar_ready,
  output logic [ID_WIDTH+IW-1:0]           m_ar_id,
  output logic [ADDR_WIDTH-1:0]            m_ar_addr,
  output logic [7:0]                       m_ar_len,
  output logic [2:0]                       m_ar_size,
  output logic [1:0]                       m_ar_burst,
  output logic [3:0]                       m_ar_snoop,
  output logic [USER_WIDTH-1:0]            m_ar_user,
  input  logic                             m_r_valid,
  output logic                             m_r_ready,
  input  logic [ID_WIDTH+IW-1:0]           m_r_id,
  input  logic [DATA_WIDTH-1:0]            m_r_data,
  input  logic [4:0]                       m_r_resp,
  input  logic                             m_r_last,
  input  logic [USER_WIDTH-1:0]            m_r_user
);

  localparam int            CW       = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTST);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [IW:0]   N_REQ_W  = (IW + 1)'(N_REQ);
`ifdef CACHE_RD_ARB_PRIO_EN
  localparam logic [IW-1:0] PTR_BASE = IW'(1);
`else
  localparam logic [IW-1:0] PTR_BASE = '0;
`endif

  logic [IW-1:0]          ptr;
  logic [CW-1:0]          cnt;
  logic [N_REQ-1:0]       rr_valid;
  logic                   hi_found;
  logic [IW-1:0]          hi_idx;
  logic [IW-1:0]          lo_idx;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          ptr_nxt;
  logic                   ar_any;
  logic                   slot_free;
  logic                   can_acc;
  logic                   ar_hs;
  logic                   r_last_hs;
  logic [IW-1:0]          r_idx;
  logic                   r_idx_ok;
  logic [ID_WIDTH-1:0]    sel_id;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [7:0]             sel_len;
  logic [2:0]             sel_size;
  logic [1:0]             sel_burst;
  logic [3:0]             sel_snoop;
  logic [USER_WIDTH-1:0]  sel_user;

  // Round-robin: first valid at or above ptr wins, else the lowest valid below it.
  always_comb begin
    rr_valid = s_ar_valid;
`ifdef CACHE_RD_ARB_PRIO_EN
    rr_valid[0] = 1'b0;
`endif
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rr_valid[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    grant = hi_found ? hi_idx : lo_idx;
`ifdef CACHE_RD_ARB_PRIO_EN
    if (s_ar_valid[0]) grant = '0;
`endif
  end

  always_comb begin
    ptr_nxt = (grant == LAST_IDX) ? PTR_BASE : grant + IW'(1);
`ifdef CACHE_RD_ARB_PRIO_EN
    // A priority grant to requester 0 leaves the rotation of the others untouched.
    if (grant == '0) ptr_nxt = ptr;
`endif
  end

  assign ar_any    = |s_ar_valid;
  assign slot_free = !m_ar_valid || m_ar_ready;
  assign can_acc   = slot_free && (cnt < MAX_CNT);
  assign ar_hs     = !rst && ar_any && can_acc;

  always_comb begin
    s_ar_ready = '0;
    sel_id     = '0;
    sel_addr   = '0;
    sel_len    = '0;
    sel_size   = '0;
    sel_burst  = '0;
    sel_snoop  = '0;
    sel_user   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IW'(i)) begin
        s_ar_ready[i] = ar_hs;
        sel_id        = s_ar_id[i*ID_WIDTH +: ID_WIDTH];
        sel_addr      = s_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len       = s_ar_len[i*8 +: 8];
        sel_size      = s_ar_size[i*3 +: 3];
        sel_burst     = s_ar_burst[i*2 +: 2];
        sel_snoop     = s_ar_snoop[i*4 +: 4];
        sel_user      = s_ar_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ar_valid <= 1'b0;
      ptr        <= PTR_BASE;
    end else if (ar_hs) begin
      m_ar_valid <= 1'b1;
      ptr        <= ptr_nxt;
    end else if (m_ar_ready) begin
      m_ar_valid <= 1'b0;
    end
  end

  // Payload only moves on an accept, so it stays put while the slot is stalled.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      m_ar_id    <= {grant, sel_id};
      m_ar_addr  <= sel_addr;
      m_ar_len   <= sel_len;
      m_ar_size  <= sel_size;
      m_ar_burst <= sel_burst;
      m_ar_snoop <= sel_snoop;
      m_ar_user  <= sel_user;
    end
  end

  assign r_last_hs = m_r_valid && m_r_ready && m_r_last && (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({ar_hs, r_last_hs})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // R beats are steered per beat by the index carried in the top id bits; an out-of-range index is sunk.
  assign r_idx    = m_r_id[ID_WIDTH+IW-1 -: IW];
  assign r_idx_ok = {1'b0, r_idx} < N_REQ_W;

  always_comb begin
    s_r_valid = '0;
    m_r_ready = !r_idx_ok;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_idx == IW'(i)) begin
        s_r_valid[i] = m_r_valid;
        m_r_ready    = s_r_ready[i];
      end
    end
  end

  assign s_r_id   = m_r_id[ID_WIDTH-1:0];
  assign s_r_data = m_r_data;
  assign s_r_resp = m_r_resp;
  assign s_r_last = m_r_last;
  assign s_r_user = m_r_user;

  illegal_r_idx_a: assert property (@(posedge clk) disable iff (rst) !(m_r_valid && !r_idx_ok));

endmodule
